// File: rtl/centipede.sv
// centipede: 384x262 video timing, test patterns, trackball cursor, status LEDs and a tone generator.
// Define CENTIPEDE_AUDIO_EN to build the tone generator; otherwise audio_o is fixed at silence.
module centipede (
  input  logic       clk_12mhz,
  input  logic       reset,
  input  logic [9:0] playerinput_i,
  input  logic [7:0] trakball_i,
  input  logic [7:0] joystick_i,
  input  logic [7:0] sw1_i,
  input  logic [7:0] sw2_i,
  output logic [3:0] led_o,
  output logic [8:0] rgb_o,
  output logic       sync_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       hblank_o,
  output logic       vblank_o,
  output logic [7:0] audio_o,
  output logic       clk_6mhz_o
);

  localparam logic [8:0] H_LAST      = 9'd383;
  localparam logic [8:0] H_ACTIVE    = 9'd256;
  localparam logic [8:0] H_SYNC_LO   = 9'd288;
  localparam logic [8:0] H_SYNC_HI   = 9'd319;
  localparam logic [8:0] V_LAST      = 9'd261;
  localparam logic [8:0] V_ACTIVE    = 9'd240;
  localparam logic [8:0] V_SYNC_LO   = 9'd244;
  localparam logic [8:0] V_SYNC_HI   = 9'd247;
  localparam logic [8:0] V_FRAME_EVT = 9'd239;

  logic       clk6_q, clk6_d;
  logic [8:0] h_q, h_d, v_q, v_d;
  logic [8:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       hblank_q, hblank_d, vblank_q, vblank_d, sync_q, sync_d;
  logic [3:0] led_q, led_d;
  logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

  logic              pix_en, h_last, v_last, frame_evt, visible;
  logic              right, left, down, up, fire_now;
  logic signed [4:0] dx, dy;
  logic signed [9:0] y_sum, y_wrap;
  logic [9:0]        hx, vy, cx_ext, cy_ext;
  logic              in_cursor;
  logic [2:0]        bar_idx;
  logic [8:0]        bar_rgb, grid_rgb, pix_rgb;

  assign pix_en    = clk6_q;
  assign h_last    = (h_q == H_LAST);
  assign v_last    = (v_q == V_LAST);
  assign frame_evt = pix_en && h_last && (v_q == V_FRAME_EVT);
  assign visible   = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);

  assign right    = ~joystick_i[4];
  assign left     = ~joystick_i[5];
  assign down     = ~joystick_i[6];
  assign up       = ~joystick_i[7];
  assign fire_now = ~playerinput_i[0] | ~playerinput_i[1];

  // Trackball nibble is two's complement; opposing joystick directions cancel.
  assign dx     = $signed({trakball_i[3], trakball_i[3:0]}) + $signed({4'd0, right})
                - $signed({4'd0, left});
  assign dy     = $signed({trakball_i[7], trakball_i[7:4]}) + $signed({4'd0, down})
                - $signed({4'd0, up});
  assign y_sum  = $signed({2'b00, cur_y_q}) + 10'(dy);
  assign y_wrap = (y_sum < 10'sd0)    ? y_sum + 10'sd240 :
                  (y_sum >= 10'sd240) ? y_sum - 10'sd240 : y_sum;

  // Square is clipped at the right/bottom edge rather than wrapping.
  assign hx        = {1'b0, h_q};
  assign vy        = {1'b0, v_q};
  assign cx_ext    = {2'b00, cur_x_q};
  assign cy_ext    = {2'b00, cur_y_q};
  assign in_cursor = (hx >= cx_ext) && (hx < cx_ext + 10'd8) &&
                     (vy >= cy_ext) && (vy < cy_ext + 10'd8);

  assign bar_idx  = h_q[7:5];
  assign bar_rgb  = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {3{bar_idx[0]}}};
  assign grid_rgb = ((h_q[2:0] == 3'd0) || (v_q[2:0] == 3'd0)) ? 9'h1FF : 9'h000;
  assign pix_rgb  = !visible                  ? 9'h000 :
                    (sw1_i[6] && in_cursor)   ? 9'h1FF :
                    sw1_i[0]                  ? bar_rgb : grid_rgb;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves a value unassigned (no latches).
    clk6_d   = ~clk6_q;
    h_d      = h_q;
    v_d      = v_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    sync_d   = sync_q;
    led_d    = led_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    if (pix_en) begin
      h_d = h_last ? 9'd0 : h_q + 9'd1;
      if (h_last) v_d = v_last ? 9'd0 : v_q + 9'd1;
      rgb_d    = pix_rgb;
      hblank_d = (h_q >= H_ACTIVE);
      hsync_d  = (h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI);
      vblank_d = (v_q >= V_ACTIVE);
      vsync_d  = (v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI);
      sync_d   = ~(hsync_d | vsync_d);
      if (frame_evt) begin
        cur_x_d = cur_x_q + 8'(dx);
        cur_y_d = 8'(y_wrap);
        led_d   = {~led_q[3], fire_now, ~playerinput_i[3], ~playerinput_i[2]};
      end
    end
  end

  always_ff @(posedge clk_12mhz or negedge reset) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge state.
    if (!reset) begin
      clk6_q   <= 1'b0;
      h_q      <= 9'd0;
      v_q      <= 9'd0;
      rgb_q    <= 9'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      sync_q   <= 1'b1;
      led_q    <= 4'd0;
      cur_x_q  <= 8'd128;
      cur_y_q  <= 8'd120;
    end else begin
      clk6_q   <= clk6_d;
      h_q      <= h_d;
      v_q      <= v_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      sync_q   <= sync_d;
      led_q    <= led_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
    end
  end

`ifdef CENTIPEDE_AUDIO_EN
  logic        fire_q, fire_d, tone_hi_q, tone_hi_d;
  logic [13:0] tone_cnt_q, tone_cnt_d, tone_last;

  // Half period of (sw2_i+1)*64 pixel enables.
  assign tone_last = {sw2_i, 6'h3F};

  always_comb begin
    fire_d     = fire_q;
    tone_cnt_d = tone_cnt_q;
    tone_hi_d  = tone_hi_q;
    if (pix_en) begin
      if (frame_evt) fire_d = fire_now;
      if (!fire_q) begin
        tone_cnt_d = 14'd0;
        tone_hi_d  = 1'b1;
      end else if (tone_cnt_q == tone_last) begin
        tone_cnt_d = 14'd0;
        tone_hi_d  = ~tone_hi_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 14'd1;
      end
    end
  end

  always_ff @(posedge clk_12mhz or negedge reset) begin
    if (!reset) begin
      fire_q     <= 1'b0;
      tone_cnt_q <= 14'd0;
      tone_hi_q  <= 1'b1;
    end else begin
      fire_q     <= fire_d;
      tone_cnt_q <= tone_cnt_d;
      tone_hi_q  <= tone_hi_d;
    end
  end

  assign audio_o = !fire_q ? 8'h80 : (tone_hi_q ? 8'hC0 : 8'h40);

  logic unused_inputs;
  assign unused_inputs = ^{playerinput_i[9:4], joystick_i[3:0], sw1_i[7], sw1_i[5:1]};
`else
  assign audio_o = 8'h80;

  logic unused_inputs;
  assign unused_inputs = ^{playerinput_i[9:4], joystick_i[3:0], sw1_i[7], sw1_i[5:1], sw2_i};
`endif

  assign clk_6mhz_o = clk6_q;
  assign rgb_o      = rgb_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign hblank_o   = hblank_q;
  assign vblank_o   = vblank_q;
  assign sync_o     = sync_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_centipede.sv
// Scoreboard bench for centipede: a pixel-index reference model queues expected outputs,
// a monitor pops one entry on every falling edge of clk_6mhz_o and compares.
module tb_centipede;

  logic       clk_12mhz = 1'b0;
  logic       reset;
  logic [9:0] playerinput_i;
  logic [7:0] trakball_i, joystick_i, sw1_i, sw2_i;
  logic [3:0] led_o;
  logic [8:0] rgb_o;
  logic       sync_o, hsync_o, vsync_o, hblank_o, vblank_o;
  logic [7:0] audio_o;
  logic       clk_6mhz_o;

  centipede dut (
    .clk_12mhz    (clk_12mhz),
    .reset        (reset),
    .playerinput_i(playerinput_i),
    .trakball_i   (trakball_i),
    .joystick_i   (joystick_i),
    .sw1_i        (sw1_i),
    .sw2_i        (sw2_i),
    .led_o        (led_o),
    .rgb_o        (rgb_o),
    .sync_o       (sync_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .hblank_o     (hblank_o),
    .vblank_o     (vblank_o),
    .audio_o      (audio_o),
    .clk_6mhz_o   (clk_6mhz_o)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  typedef struct packed {
    logic [8:0] rgb;
    logic       hs, vs, hb, vb, sync;
    logic [3:0] led;
    logic [7:0] audio;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   run_en = 1'b0;
  int   edge_n, pix_k, cx, cy, fire_pix;
  logic [3:0] m_led;
  bit   m_fire;
  logic prev_clk6 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at pixel %0d: got %h expected %h", name, pix_k, act, exp);
    end
  endtask

  task automatic model_reset();
    edge_n   = 0;
    pix_k    = -1;
    cx       = 128;
    cy       = 120;
    m_led    = 4'd0;
    m_fire   = 1'b0;
    fire_pix = 0;
    exp_q.delete();
  endtask

  function automatic logic [8:0] exp_rgb(input int h, input int v);
    int idx, r, g, b;
    if (h >= 256 || v >= 240) return 9'h000;
    if (sw1_i[6] && h >= cx && h < cx + 8 && v >= cy && v < cy + 8) return 9'h1FF;
    if (sw1_i[0]) begin
      idx = h / 32;
      r = (idx % 2) ? 7 : 0;
      g = ((idx / 2) % 2) ? 7 : 0;
      b = ((idx / 4) % 2) ? 7 : 0;
      return 9'(b * 64 + g * 8 + r);
    end
    return (h % 8 == 0 || v % 8 == 0) ? 9'h1FF : 9'h000;
  endfunction

  function automatic int sext4(input logic [3:0] n);
    return (n >= 4'd8) ? int'(n) - 16 : int'(n);
  endfunction

  task automatic frame_update();
    int  dx, dy;
    bit  fire;
    dx = sext4(trakball_i[3:0]) + int'(!joystick_i[4]) - int'(!joystick_i[5]);
    dy = sext4(trakball_i[7:4]) + int'(!joystick_i[6]) - int'(!joystick_i[7]);
    cx = (cx + dx + 256) % 256;
    cy = ((cy + dy) % 240 + 240) % 240;
    fire = !playerinput_i[0] || !playerinput_i[1];
    m_led = {~m_led[3], fire, !playerinput_i[3], !playerinput_i[2]};
    if (fire && !m_fire) fire_pix = pix_k;
    m_fire = fire;
  endtask

  function automatic logic [7:0] exp_audio();
`ifdef CENTIPEDE_AUDIO_EN
    if (!m_fire) return 8'h80;
    return (((pix_k - fire_pix) / (64 * (int'(sw2_i) + 1))) % 2 == 0) ? 8'hC0 : 8'h40;
`else
    return 8'h80;
`endif
  endfunction

  // Reference model: pixel k is registered on clk edge 2k+2 after reset release.
  always @(posedge clk_12mhz) begin
    #1;
    if (run_en) begin
      edge_n++;
      if (edge_n % 2 == 0) begin
        int   h, v;
        obs_t o;
        pix_k++;
        h = pix_k % 384;
        v = (pix_k / 384) % 262;
        o.rgb  = exp_rgb(h, v);
        o.hb   = (h >= 256);
        o.hs   = (h >= 288 && h <= 319);
        o.vb   = (v >= 240);
        o.vs   = (v >= 244 && v <= 247);
        o.sync = !(o.hs || o.vs);
        if (h == 383 && v == 239) frame_update();
        o.led   = m_led;
        o.audio = exp_audio();
        exp_q.push_back(o);
      end
    end
  end

  // Monitor: a falling clk_6mhz_o marks a freshly registered pixel.
  always @(negedge clk_12mhz) begin
    if (run_en && edge_n > 0) begin
      check("clk_6mhz", 64'(clk_6mhz_o), 64'(edge_n % 2));
      if (prev_clk6 && !clk_6mhz_o) begin
        if (exp_q.size() == 0) begin
          check("pixel_underflow", 64'(1), 64'(0));
        end else begin
          obs_t e, a;
          e = exp_q.pop_front();
          a = {rgb_o, hsync_o, vsync_o, hblank_o, vblank_o, sync_o, led_o, audio_o};
          check("pixel", 64'(a), 64'(e));
        end
      end
      prev_clk6 = clk_6mhz_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk6"}, 64'(clk_6mhz_o), 64'(0));
    check({tag, "_video"}, 64'({rgb_o, hsync_o, vsync_o, hblank_o, vblank_o, sync_o}),
          64'({9'h000, 5'b00001}));
    check({tag, "_led"}, 64'(led_o), 64'(0));
    check({tag, "_audio"}, 64'(audio_o), 64'h80);
  endtask

  task automatic wait_pix(input int target);
    while (pix_k < target) @(negedge clk_12mhz);
  endtask

  task automatic start_run();
    model_reset();
    prev_clk6 = 1'b0;
    run_en    = 1'b1;
    reset     = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    playerinput_i = 10'h3FF;
    trakball_i    = 8'h00;
    joystick_i    = 8'hFF;
    sw2_i         = 8'($urandom_range(0, 3));
    sw1_i         = (8'($urandom) & 8'hBE) | 8'h01;
    model_reset();
    repeat (3) @(negedge clk_12mhz);
    check_reset_outputs("por");

    start_run();
    wait_pix(8 * 384);
    sw1_i = (8'($urandom) & 8'hBE) | 8'h40;
    wait_pix(116 * 384);
    sw1_i = (8'($urandom) & 8'hBE) | 8'h41;
    wait_pix(131 * 384);
    sw1_i = (8'($urandom) & 8'hBE) | 8'h40;

    // Inputs that the first frame event will sample.
    wait_pix(200 * 384);
    playerinput_i = 10'($urandom) & 10'h3FE;
    trakball_i    = 8'($urandom);
    joystick_i    = 8'($urandom);

    // Second frame: fire released, but the tone keeps going until the next frame event.
    wait_pix((262 + 10) * 384);
    playerinput_i = 10'h3FF;
    trakball_i    = 8'($urandom);
    joystick_i    = 8'($urandom);
    wait_pix((262 + 140) * 384 + 77);

    // Asynchronous reset in the middle of a line.
    @(posedge clk_12mhz);
    #2;
    run_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (4) @(negedge clk_12mhz);
    check_reset_outputs("hold");

    sw1_i = (8'($urandom) & 8'hBE) | 8'h01;
    start_run();
    wait_pix(3 * 384 + 20);
    check("queue_drain", 64'(exp_q.size() <= 1), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/centipede.md
CENTIPEDE -- requirements
Module: centipede

Interface
REQ-001 SHALL provide: clk_12mhz  in  1  sole system clock, all logic on its rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL provide: playerinput_i  in  10  active-low buttons; [0] fire P1, [1] fire P2, [2] start1, [3] start2, [9:4] ignored.
REQ-004 SHALL provide: trakball_i  in  8  per-frame cursor delta; [3:0] signed X, [7:4] signed Y.
REQ-005 SHALL provide: joystick_i  in  8  active-low; [7] up, [6] down, [5] left, [4] right, [3:0] ignored.
REQ-006 SHALL provide: sw1_i  in  8  DIP; [0] pattern select, [6] cursor enable, others ignored.
REQ-007 SHALL provide: sw2_i  in  8  DIP; audio tone divider.
REQ-008 SHALL provide: led_o  out  4  status LEDs.
REQ-009 SHALL provide: rgb_o  out  9  pixel colour; [2:0] red, [5:3] green, [8:6] blue.
REQ-010 SHALL provide: sync_o, hsync_o, vsync_o, hblank_o, vblank_o  out  1 each  timing; hsync_o/vsync_o active-high, sync_o active-low composite.
REQ-011 SHALL provide: audio_o  out  8  unsigned audio sample, 8'h80 = silence.
REQ-012 SHALL provide: clk_6mhz_o  out  1  pixel clock, clk_12mhz divided by 2.

Function
REQ-013 SHALL toggle registered clk_6mhz_o every clk cycle; pixel enable = cycles where clk_6mhz_o is 1 before the edge; all state below advances only on pixel enable.
REQ-014 SHALL count hcount 0..383 (wrap to 0) and vcount 0..261, incrementing vcount when hcount wraps, vcount wrapping 261->0.
REQ-015 SHALL register, on each pixel enable, outputs for the current counter position: hblank_o = hcount>=256; hsync_o = 288<=hcount<=319; vblank_o = vcount>=240; vsync_o = 244<=vcount<=247; sync_o = ~(hsync_o|vsync_o).
REQ-016 SHALL output rgb_o = 0 whenever hblank or vblank is active.
REQ-017 SHALL, when visible and sw1_i[0]=1, output colour bars: idx = hcount[7:5], rgb_o = {3{idx[2]}},{3{idx[1]}},{3{idx[0]}} (blue,green,red).
REQ-018 SHALL, when visible and sw1_i[0]=0, output grid: 9'h1FF if hcount[2:0]==0 or vcount[2:0]==0, else 0.
REQ-019 SHALL, when sw1_i[6]=1, override with 9'h1FF for cursor_x<=hcount<cursor_x+8 and cursor_y<=vcount<cursor_y+8 (no wrap of the square).
REQ-020 SHALL update cursor once per frame, on the pixel enable where vcount becomes 240 at hcount 0: dx = sext(trakball_i[3:0]) + (right?1:0) - (left?1:0); dy likewise with [7:4], down +1, up -1; simultaneous opposing directions cancel.
REQ-021 SHALL wrap cursor_x modulo 256 and cursor_y modulo 240 (239+1 -> 0, 0-1 -> 239; deltas up to +-9).
REQ-022 SHALL register led_o at the same frame event: [0] start1 pressed, [1] start2 pressed, [2] any fire pressed, [3] toggles every frame.
REQ-023 SHALL generate audio while any fire is pressed (sampled at the frame event): square wave alternating 8'hC0/8'h40, toggling every (sw2_i+1)*64 pixel enables; otherwise 8'h80 with divider held at 0 and phase reset to 8'hC0.

Reset
REQ-024 SHALL, while reset=0, force: clk_6mhz_o=0, hcount=vcount=0, rgb_o=0, hsync_o=vsync_o=hblank_o=vblank_o=0, sync_o=1, led_o=0, audio_o=8'h80, cursor=(128,120), tone divider=0.
REQ-025 SHALL resume from the reset state on the first clk edge after reset rises; reset mid-frame restarts timing at (0,0).

Configuration
REQ-026 SHALL, with CENTIPEDE_AUDIO_EN defined, implement REQ-023; without it, audio_o SHALL be constant 8'h80 and no tone divider logic exists.

Verification
REQ-027 Reset release, inputs idle -> clk_6mhz_o toggles each clk; hsync_o period 768 clk; vsync_o period 201216 clk, high 4 lines.
REQ-028 sw1_i=8'h01 -> line 0 pixel 0 rgb 0, pixel 32 9'h007, pixel 224 9'h1FF; hcount 256 onward rgb 0.
REQ-029 sw1_i=8'h40 -> grid plus 8x8 white square at (128,120); joystick_i[4]=0 for 3 frames -> square at x=131.
REQ-030 trakball_i=8'h0F (dx=-1) from cursor (0,0) -> cursor_x 255; joystick up at y=0 -> y 239.
REQ-031 playerinput_i=10'h3FE, sw2_i=0, CENTIPEDE_AUDIO_EN defined -> after next frame event audio alternates C0/40 every 64 pixel enables, led_o[2]=1; release -> 8'h80.
REQ-032 Assert reset mid-line -> all outputs take REQ-024 values asynchronously, before the next clk edge.
